// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: digit-serial WIDTH-bit adder, one 4-bit CLA nibble per cycle
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_c;
  assign w_g = a & b;
  assign w_p = a ^ b;
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0])
                | (&w_p[3:0] & ci);
  assign s  = w_p ^ w_c[3:0];
  assign co = w_c[4];
endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_c_out, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [3:0]       w_s;
  logic             w_co;
  cla4 u_cla (
    .a  (r_a[4*r_cnt +: 4]),
    .b  (r_b[4*r_cnt +: 4]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = (r_cnt == LAST) ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    busy      = r_state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= c_in;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_sum[4*r_cnt +: 4] <= w_s;
      r_carry             <= w_co;
      r_cnt               <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_c_out <= w_co;
        // the final nibble's top bit is the sign of the finished sum
        r_ovf   <= (r_a[WIDTH-1] ~^ r_b[WIDTH-1]) & (w_s[3] ^ r_a[WIDTH-1]);
      end
    end
  end
  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: directed vector table plus stall and mid-run reset sequences
module tb_cla_nibble_serial_adder;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0, c_in = 0;
  logic [15:0] a = 0, b = 0;
  logic        in_ready, out_valid, c_out, ovf, busy;
  logic [15:0] sum;
  int          n_chk = 0, n_fail = 0;
  logic        prev_cout = 0, prev_ovf = 0;
  typedef struct {
    logic [15:0] a, b;
    logic        ci;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;
  vec_t vecs [7];

  cla_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [15:0] ta, input logic [15:0] tb, input logic tci);
    chk("in_ready_before_send", 32'(in_ready), 1);
    a = ta; b = tb; c_in = tci; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; a = ~ta; b = 16'h5A5A ^ tb; c_in = ~tci;
    chk("busy_after_accept", 32'(busy), 1);
    chk("in_ready_after_accept", 32'(in_ready), 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        chk("c_out_held_in_run", 32'(c_out), 32'(prev_cout));
        chk("ovf_held_in_run", 32'(ovf), 32'(prev_ovf));
      end
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 4);
  endtask

  task automatic finish_op(input vec_t v, input string tag);
    chk({tag, "_sum"}, 32'(sum), 32'(v.s));
    chk({tag, "_c_out"}, 32'(c_out), 32'(v.co));
    chk({tag, "_ovf"}, 32'(ovf), 32'(v.ov));
    chk({tag, "_in_ready_done"}, 32'(in_ready), 0);
    prev_cout = v.co; prev_ovf = v.ov;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, "_out_valid_cleared"}, 32'(out_valid), 0);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 1);
  endtask

  initial begin
    int   lat;
    vec_t v;
    logic [15:0] held;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_c_out", 32'(c_out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst = 0;
    @(posedge clk); #1;
    out_ready = 1;
    @(posedge clk); #1;
    chk("stray_out_ready_idle", 32'(busy), 0);
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].ci);
      wait_done(lat);
      finish_op(vecs[i], $sformatf("vec%0d", i));
    end
    // stall in DONE with noisy inputs
    accept(16'h1234, 16'h4321, 1'b0);
    wait_done(lat);
    held = sum;
    chk("stall_first_sum", 32'(held), 32'h5555);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid; a = 16'(i * 16'h1111); b = ~a;
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_sum", 32'(sum), 32'h5555);
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("stall_release_out_valid", 32'(out_valid), 0);
    chk("stall_release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    chk("stall_nothing_accepted", 32'(busy), 0);
    prev_cout = 0; prev_ovf = 0;
    // abort mid-run with async reset
    accept(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_before_rst", 32'(busy), 1);
    rst = 1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    v = vecs[6];
    accept(v.a, v.b, v.ci);
    wait_done(lat);
    finish_op(v, "after_abort");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
